md_hilo_ctrl: RTL and testbench

Multi-cycle multiply/divide controller and HI/LO register owner for the EX stage of the MIPS pipeline. It consumes the 6-bit instruction code produced by instruction decode: 11 DIV, 12 DIVU, 13 MULT, 14 MULTU, 41 MFHI, 42 MFLO, 43 MTHI, 44 MTLO. It sequences an iterative radix-2 divider and a fixed-latency multiplier, stalls the pipeline until the result is written to HI/LO, and serves MFHI/MFLO reads and MTHI/MTLO writes.

---
 rtl/md_hilo_ctrl.sv | 155 +++++++++++++++
 tb/tb_md_hilo_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_hilo_ctrl.sv
`timescale 1ns/1ps
// EX-stage multiply/divide sequencer and HI/LO owner: MULT/MULTU take 1+MUL_CYCLES stall cycles, DIV/DIVU 33.
// Holds the pipeline via stall until completion; results retire in a one-cycle DONE state, and ex_flush cancels at any point.
module md_hilo_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [5:0]  ex_inscode,
  input  logic [31:0] ex_rs_val,
  input  logic [31:0] ex_rt_val,
  input  logic        ex_flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] mf_data
);

  localparam logic [5:0] CODE_DIV   = 6'd11;
  localparam logic [5:0] CODE_DIVU  = 6'd12;
  localparam logic [5:0] CODE_MULT  = 6'd13;
  localparam logic [5:0] CODE_MULTU = 6'd14;
  localparam logic [5:0] CODE_MFHI  = 6'd41;
  localparam logic [5:0] CODE_MFLO  = 6'd42;
  localparam logic [5:0] CODE_MTHI  = 6'd43;
  localparam logic [5:0] CODE_MTLO  = 6'd44;
  localparam logic [5:0] MUL_LAST   = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LAST   = 6'd31;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] rsLat, rtLat, divMag, remReg, quoReg;
  logic        isSigned;

  logic        issueOk, issueDiv, issueMul, issueMt, issueSigned;
  logic [31:0] rsMag, rtMag;
  logic [63:0] mulA, mulB, product;
  logic [32:0] remShift, diff;
  logic        geq, negQ, negR, divZero;
  logic [31:0] remNext, quoNext, divLo, divHi;

  always_comb begin
    issueOk     = (state == IDLE) && ex_valid && !ex_flush;
    issueDiv    = issueOk && (ex_inscode == CODE_DIV  || ex_inscode == CODE_DIVU);
    issueMul    = issueOk && (ex_inscode == CODE_MULT || ex_inscode == CODE_MULTU);
    issueMt     = issueOk && (ex_inscode == CODE_MTHI || ex_inscode == CODE_MTLO);
    issueSigned = (ex_inscode == CODE_DIV);
    rsMag       = (issueSigned && ex_rs_val[31]) ? -ex_rs_val : ex_rs_val;
    rtMag       = (issueSigned && ex_rt_val[31]) ? -ex_rt_val : ex_rt_val;
  end

  assign stall = issueDiv || issueMul || (!ex_flush && (state == MUL || state == DIV));
  assign busy  = (state != IDLE);

  always_comb begin
    mf_data = '0;
    if (ex_inscode == CODE_MFHI)      mf_data = hi_o;
    else if (ex_inscode == CODE_MFLO) mf_data = lo_o;
  end

  // Sign-extending to 64 bits makes one truncated multiply serve both MULT and MULTU.
  always_comb begin
    mulA    = {{32{isSigned & rsLat[31]}}, rsLat};
    mulB    = {{32{isSigned & rtLat[31]}}, rtLat};
    product = mulA * mulB;
  end

  // One restoring step; quoReg shifts dividend bits out the top and quotient bits in at the bottom.
  always_comb begin
    remShift = {remReg, quoReg[31]};
    diff     = remShift - {1'b0, divMag};
    geq      = ~diff[32];
    remNext  = geq ? diff[31:0] : remShift[31:0];
    quoNext  = {quoReg[30:0], geq};
    negQ     = isSigned & (rsLat[31] ^ rtLat[31]);
    negR     = isSigned & rsLat[31];
    divZero  = (rtLat == '0);
    divLo    = divZero ? 32'hFFFF_FFFF : (negQ ? -quoNext : quoNext);
    divHi    = divZero ? rsLat : (negR ? -remNext : remNext);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_o     <= '0;
      lo_o     <= '0;
      rsLat    <= '0;
      rtLat    <= '0;
      divMag   <= '0;
      remReg   <= '0;
      quoReg   <= '0;
      isSigned <= 1'b0;
    end else if (ex_flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issueDiv) begin
            rsLat    <= ex_rs_val;
            rtLat    <= ex_rt_val;
            isSigned <= issueSigned;
            divMag   <= rtMag;
            quoReg   <= rsMag;
            remReg   <= '0;
            cnt      <= '0;
            state    <= DIV;
          end else if (issueMul) begin
            rsLat    <= ex_rs_val;
            rtLat    <= ex_rt_val;
            isSigned <= (ex_inscode == CODE_MULT);
            cnt      <= '0;
            state    <= MUL;
          end else if (issueMt) begin
            if (ex_inscode == CODE_MTHI) hi_o <= ex_rs_val;
            else                         lo_o <= ex_rs_val;
          end
        end
        MUL: begin
          if (cnt == MUL_LAST) begin
            hi_o  <= product[63:32];
            lo_o  <= product[31:0];
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DIV: begin
          remReg <= remNext;
          quoReg <= quoNext;
          if (cnt == DIV_LAST) begin
            lo_o  <= divLo;
            hi_o  <= divHi;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
`timescale 1ns/1ps
// Bench for md_hilo_ctrl: directed corner cases plus randomized MD/MT traffic against an arithmetic reference.
module tb_md_hilo_ctrl;

  localparam int MULC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [5:0]  ex_inscode;
  logic [31:0] ex_rs_val, ex_rt_val;
  logic        ex_flush;
  logic        stall, busy;
  logic [31:0] hi_o, lo_o, mf_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;

  md_hilo_ctrl #(.MUL_CYCLES(MULC)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_inscode(ex_inscode),
    .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_flush(ex_flush),
    .stall(stall), .busy(busy), .hi_o(hi_o), .lo_o(lo_o), .mf_data(mf_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference result from plain integer arithmetic on the instruction semantics.
  function automatic void mdRef(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = modelHi;
    l = modelLo;
    case (code)
      6'd13: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      6'd14: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      6'd11, 6'd12: begin
        if (b == 0) begin
          l = 32'hFFFF_FFFF; h = a;
        end else if (code == 6'd11) begin
          q = sa / sb; r = sa % sb;
          l = 32'(q); h = 32'(r);
        end else begin
          l = a / b; h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic mdOp(input string tag, input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
    int n;
    int lat;
    logic [31:0] eh, el;
    mdRef(code, a, b, eh, el);
    lat = (code == 6'd13 || code == 6'd14) ? 1 + MULC : 33;
    ex_valid = 1'b1; ex_inscode = code; ex_rs_val = a; ex_rt_val = b;
    n = 0;
    @(negedge clk);
    while (stall === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, " stall cycles"}, 32'(n), 32'(lat));
    check({tag, " busy in DONE"}, {31'b0, busy}, 32'd1);
    check({tag, " hi"}, hi_o, eh);
    check({tag, " lo"}, lo_o, el);
    modelHi = eh; modelLo = el;
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic mtOp(input string tag, input logic [5:0] code, input logic [31:0] v);
    ex_valid = 1'b1; ex_inscode = code; ex_rs_val = v;
    @(negedge clk);
    check({tag, " stall"}, {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (code == 6'd43) modelHi = v; else modelLo = v;
    check({tag, " hi"}, hi_o, modelHi);
    check({tag, " lo"}, lo_o, modelLo);
  endtask

  task automatic mfCheck(input string tag);
    ex_valid = 1'b1;
    ex_inscode = 6'd41; #1;
    check({tag, " mfhi"}, mf_data, modelHi);
    ex_inscode = 6'd42; #1;
    check({tag, " mflo"}, mf_data, modelLo);
    ex_inscode = 6'd7; #1;
    check({tag, " mf other"}, mf_data, 32'd0);
    ex_valid = 1'b0;
  endtask

  initial begin
    logic [5:0] codes [6];
    codes = '{6'd11, 6'd12, 6'd13, 6'd14, 6'd43, 6'd44};
    rst = 1'b1; ex_valid = 1'b0; ex_inscode = '0; ex_rs_val = '0; ex_rt_val = '0; ex_flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset hi", hi_o, 32'd0);
    check("reset lo", lo_o, 32'd0);
    check("reset stall", {31'b0, stall}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    mdOp("mult -3*7", 6'd13, 32'hFFFF_FFFD, 32'd7);
    mdOp("multu", 6'd14, 32'hFFFF_FFFD, 32'd7);
    mdOp("divu 100/7", 6'd12, 32'd100, 32'd7);
    mdOp("div -7/2", 6'd11, 32'hFFFF_FFF9, 32'd2);
    mdOp("div ovf", 6'd11, 32'h8000_0000, 32'hFFFF_FFFF);
    mdOp("div by 0", 6'd11, 32'h1234_5678, 32'd0);
    mdOp("divu by 0", 6'd12, 32'h8765_4321, 32'd0);
    mfCheck("after div0");

    // Flush on the 10th stall cycle of a DIVU
    mtOp("pre hi", 6'd43, 32'hAAAA_0000);
    mtOp("pre lo", 6'd44, 32'h0000_5555);
    ex_valid = 1'b1; ex_inscode = 6'd12; ex_rs_val = 32'd100; ex_rt_val = 32'd7;
    repeat (9) @(posedge clk);
    #1;
    check("flush10 pre stall", {31'b0, stall}, 32'd1);
    ex_flush = 1'b1;
    @(negedge clk);
    check("flush10 stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    ex_flush = 1'b0; ex_valid = 1'b0;
    check("flush10 busy", {31'b0, busy}, 32'd0);
    check("flush10 hi", hi_o, modelHi);
    check("flush10 lo", lo_o, modelLo);
    mtOp("mthi cafe", 6'd43, 32'hCAFE_BABE);
    mfCheck("after mthi");

    // Flush in the final DIV cycle
    ex_valid = 1'b1; ex_inscode = 6'd11; ex_rs_val = 32'd1000; ex_rt_val = 32'd3;
    repeat (32) @(posedge clk);
    #1;
    check("flush31 pre stall", {31'b0, stall}, 32'd1);
    ex_flush = 1'b1;
    @(negedge clk);
    check("flush31 stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    ex_flush = 1'b0; ex_valid = 1'b0;
    check("flush31 busy", {31'b0, busy}, 32'd0);
    check("flush31 hi", hi_o, modelHi);
    check("flush31 lo", lo_o, modelLo);

    // Flush coincident with issue, and with an MT write
    ex_valid = 1'b1; ex_inscode = 6'd13; ex_rs_val = 32'd5; ex_rt_val = 32'd6; ex_flush = 1'b1;
    @(negedge clk);
    check("flush issue stall", {31'b0, stall}, 32'd0);
    ex_inscode = 6'd43; ex_rs_val = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("flush issue busy", {31'b0, busy}, 32'd0);
    check("flush mt hi", hi_o, modelHi);
    ex_flush = 1'b0; ex_valid = 1'b0;

    // Unknown code does nothing
    ex_valid = 1'b1; ex_inscode = 6'd20; ex_rs_val = 32'h1111_2222;
    @(negedge clk);
    check("unknown stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    check("unknown busy", {31'b0, busy}, 32'd0);
    check("unknown lo", lo_o, modelLo);

    // Back-to-back: MULT then DIVU with no idle gap beyond the mandatory one
    mdOp("b2b mult", 6'd13, 32'h7FFF_FFFF, 32'h8000_0000);
    mdOp("b2b divu", 6'd12, 32'hFFFF_FFFF, 32'd16);
    mfCheck("b2b");

    for (int i = 0; i < 30; i++) begin
      logic [5:0]  c;
      logic [31:0] a, b;
      c = codes[$urandom_range(0, 5)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 20);
        2:       b = -($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if (c == 6'd43 || c == 6'd44) mtOp("rand mt", c, a);
      else                          mdOp("rand md", c, a, b);
      if (i % 5 == 4) mfCheck("rand mf");
    end

    // Reset held 2 cycles mid-DIV
    ex_valid = 1'b1; ex_inscode = 6'd12; ex_rs_val = 32'd100; ex_rt_val = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; ex_valid = 1'b0;
    @(negedge clk);
    check("rst mid hi", hi_o, 32'd0);
    check("rst mid lo", lo_o, 32'd0);
    check("rst mid stall", {31'b0, stall}, 32'd0);
    check("rst mid busy", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
